jk_bank_driver: RTL and testbench
=================================

# jk_bank_driver

Drives the J/K inputs of an external bank of WIDTH `jkff` cells so that the bank reaches a requested target word. It takes each target through a valid/ready handshake and computes the minimal J/K excitation per bit from the bank's fed-back Q. It applies that excitation for one clock, checks the result, retries up to MAX_TRIES times, then reports DONE or ERROR. It is the controlling end of the J/K interface and shares the bank's clock and reset.

## Interface
- WIDTH, 4, number of J/K flip-flops driven.
- MAX_TRIES, 3, maximum apply/check attempts per target (≥1).
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous reset, active high.
- TARGET  input  WIDTH  requested Q word for the bank.
- T_VALID  input  1  TARGET valid.
- T_READY  output  1  driver can accept a target; high only in IDLE.
- Q_FB  input  WIDTH  Q outputs of the driven bank.
- J  output  WIDTH  registered J drive to the bank.
- K  output  WIDTH  registered K drive to the bank.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse: Q_FB matched the target.
- ERROR  output  1  one-cycle pulse: MAX_TRIES exhausted without a match.
- FAIL_MASK  output  WIDTH  Q_FB XOR target at the last check; held until the next accept.

## Operation
- States: IDLE, EXCITE, APPLY, CHECK.
- IDLE: T_READY=1. When T_VALID&&T_READY at a rising edge, latch TARGET into TGT, clear the attempt counter and FAIL_MASK, and go to EXCITE.
- EXCITE: compute the per-bit excitation from TGT[i] and Q_FB[i], then register it into J/K at the end of the cycle and go to APPLY.
  - Q=0, want 0: J=0, K=0.
  - Q=0, want 1: J=1, K=0.
  - Q=1, want 0: J=0, K=1.
  - Q=1, want 1: J=0, K=0.
  - Don't-cares always resolve to 0. J&K is never 1 on any bit (toggle mode unused).
- APPLY: J/K are presented for this cycle and the bank captures them at the closing edge. At that edge J and K go to 0, and the state goes to CHECK.
- CHECK: FAIL_MASK <= Q_FB ^ TGT.
  - Zero mismatch: DONE=1 next cycle, go to IDLE.
  - Else, attempt+1 == MAX_TRIES: ERROR=1 next cycle, go to IDLE.
  - Else: increment the attempt counter, go to EXCITE.
- The attempt counter is $clog2(MAX_TRIES+1) bits wide and never wraps.
- TARGET equal to the current Q still runs the full sequence, with J=K=0, and ends in DONE.
- T_VALID outside IDLE is ignored; TGT does not change until the next accept.

## Timing
- Cycle n = the n-th clock cycle after the accepting edge.
- Nominal sequence: EXCITE in c1, J/K valid in c2, CHECK in c3, DONE and T_READY high in c4.
- Each retry adds 3 cycles. The final ERROR pulse lands in cycle 3·MAX_TRIES+1.
- A new target can be accepted at the edge that ends c4 (the DONE cycle).
- J and K are non-zero only during APPLY cycles.
- Reset values: J=0, K=0, DONE=0, ERROR=0, FAIL_MASK=0, BUSY=0, state IDLE, T_READY=1.
- RESET asserted at any point, including mid-APPLY, forces all of the above immediately and asynchronously. No DONE or ERROR follows. The aborted target is discarded.
- No handshake is accepted while RESET is high.
- Q_FB is treated as synchronous to CLK; no synchronizer.

## Test plan
- Reset: assert RESET mid-idle → J=K=0000, DONE=ERROR=BUSY=0, T_READY=1; release, no spurious pulse for 10 cycles.
- Loopback bank at 0000, accept TARGET=1010 → c2 J=1010 K=0000, c3 Q_FB=1010, c4 DONE=1, FAIL_MASK=0000, T_READY=1.
- Bank at 1010, accept TARGET=0110 → c2 J=0100 K=1000; DONE in c4; bank reads 0110.
- Bank at 0110, accept TARGET=0110 → c2 J=K=0000; DONE in c4; bank unchanged.
- Bit0 of the bank stuck at 0, MAX_TRIES=3, accept TARGET=0001 → J=0001 in c2, c5 and c8; ERROR=1 in c10; FAIL_MASK=0001; no DONE.
- Assert RESET during c2 (APPLY) of a 0000→1111 request → J/K drop to 0 within the same cycle, state IDLE, T_READY=1 after release, no DONE or ERROR; the next request completes normally.

Source files
------------

// File: rtl/jk_bank_driver.sv
// Drives the J/K inputs of an external jkff bank toward a latched target, retrying up to MAX_TRIES.
// Nominal latency: DONE in cycle 4 after accept, +3 cycles per retry; T_READY only in IDLE, T_VALID ignored otherwise.
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_TRIES = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] TARGET,
  input  logic             T_VALID,
  output logic             T_READY,
  input  logic [WIDTH-1:0] Q_FB,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [WIDTH-1:0] FAIL_MASK
);

  localparam int AW = $clog2(MAX_TRIES + 1);
  localparam logic [AW-1:0] LAST_TRY = AW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXCITE,
    S_APPLY,
    S_CHECK
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [AW-1:0]    attempt_q, attempt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] fail_mask_q, fail_mask_d;
  logic [WIDTH-1:0] mismatch;

  assign mismatch = Q_FB ^ tgt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      tgt_q       <= '0;
      attempt_q   <= '0;
      j_q         <= '0;
      k_q         <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      fail_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      attempt_q   <= attempt_d;
      j_q         <= j_d;
      k_q         <= k_d;
      done_q      <= done_d;
      error_q     <= error_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    attempt_d   = attempt_q;
    j_d         = '0;
    k_d         = '0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    fail_mask_d = fail_mask_q;

    case (state_q)
      S_IDLE: begin
        if (T_VALID) begin
          tgt_d       = TARGET;
          attempt_d   = '0;
          fail_mask_d = '0;
          state_d     = S_EXCITE;
        end
      end
      S_EXCITE: begin
        // Minimal excitation: set-only or reset-only, never toggle.
        j_d     = tgt_q & ~Q_FB;
        k_d     = ~tgt_q & Q_FB;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        fail_mask_d = mismatch;
        if (mismatch == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (attempt_q == LAST_TRY) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          attempt_d = attempt_q + AW'(1);
          state_d   = S_EXCITE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign T_READY   = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign J         = j_q;
  assign K         = k_q;
  assign DONE      = done_q;
  assign ERROR     = error_q;
  assign FAIL_MASK = fail_mask_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench: jk_bank_driver driving a behavioural jkff bank with optional stuck-at-0 bits.
module tb_jk_bank_driver;

  logic       clk;
  logic       rst;
  logic [3:0] target;
  logic       t_valid;
  logic       t_ready;
  logic [3:0] q_fb;
  logic [3:0] j;
  logic [3:0] k;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] fail_mask;

  logic [3:0] bank_q;
  logic [3:0] stuck0;

  int total;
  int passed;
  int pulses;

  jk_bank_driver #(.WIDTH(4), .MAX_TRIES(3)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .TARGET   (target),
    .T_VALID  (t_valid),
    .T_READY  (t_ready),
    .Q_FB     (q_fb),
    .J        (j),
    .K        (k),
    .BUSY     (busy),
    .DONE     (done),
    .ERROR    (error),
    .FAIL_MASK(fail_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK characteristic equation: Q+ = J&~Q | ~K&Q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bank_q <= '0;
    else     bank_q <= (j & ~bank_q) | (~k & bank_q);
  end
  assign q_fb = bank_q & ~stuck0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Caller sits at a negedge; accept happens at the following posedge.
  task automatic go(input logic [3:0] t);
    target  = t;
    t_valid = 1'b1;
    @(posedge clk);
    #1 t_valid = 1'b0;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_j"}, 32'(j), 32'h0);
    chk({tag, "_k"}, 32'(k), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_error"}, 32'(error), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_rdy"}, 32'(t_ready), 32'h1);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 idle_checks(tag);
    chk({tag, "_fmask"}, 32'(fail_mask), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    rst     = 1'b1;
    target  = '0;
    t_valid = 1'b0;
    stuck0  = '0;

    // Power-up reset
    #3 idle_checks("por");
    chk("por_fmask", 32'(fail_mask), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-idle, then quiet for 10 cycles
    reset_pulse("rst_idle");
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || error || busy) pulses++;
    end
    chk("rst_quiet", 32'(pulses), 32'h0);

    // 0000 -> 1010, with a competing T_VALID held during the busy cycles
    go(4'b1010);
    @(negedge clk);                                  // c1
    chk("t2_c1_busy", 32'(busy), 32'h1);
    chk("t2_c1_rdy", 32'(t_ready), 32'h0);
    target  = 4'b0101;
    t_valid = 1'b1;
    @(negedge clk);                                  // c2
    chk("t2_c2_j", 32'(j), 32'hA);
    chk("t2_c2_k", 32'(k), 32'h0);
    @(negedge clk);                                  // c3
    t_valid = 1'b0;
    chk("t2_c3_qfb", 32'(q_fb), 32'hA);
    chk("t2_c3_j", 32'(j), 32'h0);
    chk("t2_c3_done", 32'(done), 32'h0);
    @(negedge clk);                                  // c4
    chk("t2_c4_done", 32'(done), 32'h1);
    chk("t2_c4_fmask", 32'(fail_mask), 32'h0);
    chk("t2_c4_rdy", 32'(t_ready), 32'h1);

    // Back-to-back accept at the end of the DONE cycle: 1010 -> 0110
    go(4'b0110);
    @(negedge clk);                                  // c1
    chk("t3_c1_done", 32'(done), 32'h0);
    @(negedge clk);                                  // c2
    chk("t3_c2_j", 32'(j), 32'h4);
    chk("t3_c2_k", 32'(k), 32'h8);
    repeat (2) @(negedge clk);                       // c4
    chk("t3_c4_done", 32'(done), 32'h1);
    chk("t3_bank", 32'(q_fb), 32'h6);

    // Target equal to current Q
    go(4'b0110);
    @(negedge clk);
    @(negedge clk);                                  // c2
    chk("t4_c2_j", 32'(j), 32'h0);
    chk("t4_c2_k", 32'(k), 32'h0);
    chk("t4_c2_busy", 32'(busy), 32'h1);
    repeat (2) @(negedge clk);                       // c4
    chk("t4_c4_done", 32'(done), 32'h1);
    chk("t4_bank", 32'(q_fb), 32'h6);

    // Abort mid-APPLY of 0000 -> 1111
    reset_pulse("rst_pre_abort");
    @(negedge clk);
    go(4'b1111);
    @(negedge clk);
    @(negedge clk);                                  // c2
    chk("ab_c2_j", 32'(j), 32'hF);
    #2 rst = 1'b1;
    #1 idle_checks("ab_rst");
    target  = 4'b0101;
    t_valid = 1'b1;
    @(negedge clk);
    chk("ab_no_accept", 32'(busy), 32'h0);
    t_valid = 1'b0;
    rst     = 1'b0;
    pulses  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || error || busy) pulses++;
    end
    chk("ab_quiet", 32'(pulses), 32'h0);
    chk("ab_rdy", 32'(t_ready), 32'h1);

    // Recovery request completes normally
    go(4'b1111);
    @(negedge clk);
    @(negedge clk);                                  // c2
    chk("rec_c2_j", 32'(j), 32'hF);
    repeat (2) @(negedge clk);                       // c4
    chk("rec_c4_done", 32'(done), 32'h1);
    chk("rec_bank", 32'(q_fb), 32'hF);

    // Bit0 stuck at 0: three attempts, then ERROR
    reset_pulse("rst_pre_stuck");
    stuck0 = 4'b0001;
    @(negedge clk);
    go(4'b0001);
    pulses = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (done) pulses++;
      if (c == 2 || c == 5 || c == 8) begin
        chk($sformatf("st_c%0d_j", c), 32'(j), 32'h1);
        chk($sformatf("st_c%0d_k", c), 32'(k), 32'h0);
      end
      if (c == 3) chk("st_c3_j", 32'(j), 32'h0);
      if (c == 9) chk("st_c9_error", 32'(error), 32'h0);
      if (c == 10) begin
        chk("st_c10_error", 32'(error), 32'h1);
        chk("st_c10_fmask", 32'(fail_mask), 32'h1);
        chk("st_c10_rdy", 32'(t_ready), 32'h1);
      end
      if (c == 11) begin
        chk("st_c11_error", 32'(error), 32'h0);
        chk("st_c11_fmask", 32'(fail_mask), 32'h1);
      end
    end
    chk("st_no_done", 32'(pulses), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
